// File: rtl/vend_if.sv
// rtl/vend_if.sv - handshake bundle between the vending front end and vend_controller
//
// Purpose: groups the selection, coin, cancel and result signals of the
// vending transaction controller.
// master: drives product_sel/product_cost/sel_valid/coin/coin_valid/cancel,
//         observes the result pulses and status.
// slave : the controller side (vend_controller).
interface vend_if;
  logic [1:0] product_sel;
  logic [5:0] product_cost;
  logic       sel_valid;
  logic [1:0] coin;
  logic       coin_valid;
  logic       cancel;
  logic       dispense;
  logic [1:0] dispensed_product;
  logic       change_valid;
  logic [5:0] change;
  logic [5:0] credit;
  logic       coin_reject;
  logic       sel_error;
  logic       busy;

  modport master (
    output product_sel, product_cost, sel_valid, coin, coin_valid, cancel,
    input  dispense, dispensed_product, change_valid, change, credit,
           coin_reject, sel_error, busy
  );

  modport slave (
    input  product_sel, product_cost, sel_valid, coin, coin_valid, cancel,
    output dispense, dispensed_product, change_valid, change, credit,
           coin_reject, sel_error, busy
  );
endinterface

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction controller (select, collect, dispense, change)
//
// Purpose: latches a product selection and its cost, accumulates coins into
// credit, then emits a one-cycle dispense pulse followed by a one-cycle
// change pulse. Cancel and inactivity timeout refund the full credit.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - vend_if.slave: selection/coin/cancel inputs, registered result
//          pulses (dispense, change_valid, coin_reject, sel_error) and
//          status (credit, busy, change, dispensed_product)
// Parameter:
//   TIMEOUT_CYCLES - coin-free COLLECT cycles before automatic refund (>= 2)
module vend_controller #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t        state;
  logic [1:0]    sel_q;
  logic [5:0]    cost_q;
  logic [5:0]    credit_q;
  logic [5:0]    change_q;
  logic [1:0]    dispensed_q;
  logic [CW-1:0] tmo_cnt;
  logic          dispense_q;
  logic          change_valid_q;
  logic          coin_reject_q;
  logic          sel_error_q;
  logic          busy_q;

  logic       coin_ok;
  logic [5:0] coin_value;
  logic [5:0] credit_sum;

  always_comb begin
    coin_value = 6'd0;
    case (bus.coin)
      2'b00:   coin_value = 6'd5;
      2'b01:   coin_value = 6'd10;
      2'b10:   coin_value = 6'd20;
      default: coin_value = 6'd0;
    endcase
  end

  assign coin_ok    = (bus.coin != 2'b11);
  // Credit stays <= 55 for the supported cost range, so 6 bits cannot wrap.
  assign credit_sum = credit_q + coin_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      sel_q          <= 2'd0;
      cost_q         <= 6'd0;
      credit_q       <= 6'd0;
      change_q       <= 6'd0;
      dispensed_q    <= 2'd0;
      tmo_cnt        <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_error_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // Pulse outputs default low; each branch raises them for one cycle.
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_error_q    <= 1'b0;

      case (state)
        S_IDLE: begin
          coin_reject_q <= bus.coin_valid;
          if (bus.sel_valid) begin
            if (bus.product_cost != 6'd0) begin
              sel_q   <= bus.product_sel;
              cost_q  <= bus.product_cost;
              tmo_cnt <= '0;
              busy_q  <= 1'b1;
              state   <= S_COLLECT;
            end else begin
              sel_error_q <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (bus.cancel) begin
            // Cancel wins; any coin presented alongside it is handed back.
            coin_reject_q  <= bus.coin_valid;
            change_q       <= credit_q;
            change_valid_q <= 1'b1;
            state          <= S_CHANGE;
          end else if (bus.coin_valid && coin_ok) begin
            credit_q <= credit_sum;
            tmo_cnt  <= '0;
            if (credit_sum >= cost_q) begin
              dispense_q  <= 1'b1;
              dispensed_q <= sel_q;
              state       <= S_DISPENSE;
            end
          end else begin
            // An invalid coin is rejected but counts as an idle cycle.
            coin_reject_q <= bus.coin_valid;
            if (tmo_cnt == TERM) begin
              change_q       <= credit_q;
              change_valid_q <= 1'b1;
              state          <= S_CHANGE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        S_DISPENSE: begin
          coin_reject_q  <= bus.coin_valid;
          change_q       <= credit_q - cost_q;
          change_valid_q <= 1'b1;
          state          <= S_CHANGE;
        end

        S_CHANGE: begin
          coin_reject_q <= bus.coin_valid;
          credit_q      <= 6'd0;
          busy_q        <= 1'b0;
          state         <= S_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dispense          = dispense_q;
  assign bus.dispensed_product = dispensed_q;
  assign bus.change_valid      = change_valid_q;
  assign bus.change            = change_q;
  assign bus.credit            = credit_q;
  assign bus.coin_reject       = coin_reject_q;
  assign bus.sel_error         = sel_error_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller
module tb_vend_controller;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_if bus();

  vend_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int coin_val[3] = '{5, 10, 20};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int cost_of(input int code);
    case (code)
      0: return 10;
      1: return 20;
      2: return 40;
      default: return 0;
    endcase
  endfunction

  task automatic do_sel(input int code, input int cost);
    bus.product_sel  = code[1:0];
    bus.product_cost = cost[5:0];
    bus.sel_valid    = 1'b1;
    step();
    bus.sel_valid    = 1'b0;
  endtask

  task automatic do_coin(input int code);
    bus.coin       = code[1:0];
    bus.coin_valid = 1'b1;
    step();
    bus.coin_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++;
    if ({bus.dispense, bus.dispensed_product, bus.change_valid, bus.change, bus.credit,
         bus.coin_reject, bus.sel_error, bus.busy} !== 20'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.dispense, bus.dispensed_product, bus.change_valid, bus.change, bus.credit,
                bus.coin_reject, bus.sel_error, bus.busy});
    end
  endtask

  task automatic test_exact_payment;
    do_sel(1, cost_of(1));
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL exact_busy: got %b expected 1", bus.busy); end
    do_coin(1);
    tests++;
    if (bus.credit !== 6'd10 || bus.dispense !== 1'b0) begin
      fails++; $display("FAIL exact_credit1: got credit %0d dispense %b expected 10/0", bus.credit, bus.dispense);
    end
    do_coin(1);
    tests++;
    if (bus.credit !== 6'd20 || bus.dispense !== 1'b1 || bus.dispensed_product !== 2'd1) begin
      fails++; $display("FAIL exact_dispense: got credit %0d dispense %b prod %0d expected 20/1/1",
                        bus.credit, bus.dispense, bus.dispensed_product);
    end
    step();
    tests++;
    if (bus.change_valid !== 1'b1 || bus.change !== 6'd0 || bus.dispense !== 1'b0) begin
      fails++; $display("FAIL exact_change: got cv %b change %0d dispense %b expected 1/0/0",
                        bus.change_valid, bus.change, bus.dispense);
    end
    step();
    tests++;
    if (bus.busy !== 1'b0 || bus.change_valid !== 1'b0 || bus.credit !== 6'd0) begin
      fails++; $display("FAIL exact_idle: got busy %b cv %b credit %0d expected 0/0/0",
                        bus.busy, bus.change_valid, bus.credit);
    end
  endtask

  task automatic test_overpayment;
    int exp_credit[3] = '{20, 25, 45};
    int codes[3]      = '{2, 0, 2};
    do_sel(2, cost_of(2));
    for (int i = 0; i < 3; i++) begin
      do_coin(codes[i]);
      tests++;
      if (bus.credit !== exp_credit[i][5:0]) begin
        fails++; $display("FAIL over_credit%0d: got %0d expected %0d", i, bus.credit, exp_credit[i]);
      end
    end
    tests++;
    if (bus.dispense !== 1'b1 || bus.dispensed_product !== 2'd2) begin
      fails++; $display("FAIL over_dispense: got %b prod %0d expected 1/2", bus.dispense, bus.dispensed_product);
    end
    step();
    tests++;
    if (bus.change_valid !== 1'b1 || bus.change !== 6'd5) begin
      fails++; $display("FAIL over_change: got cv %b change %0d expected 1/5", bus.change_valid, bus.change);
    end
    step();
  endtask

  task automatic test_cancel_with_coin;
    do_sel(0, cost_of(0));
    do_coin(0);
    bus.cancel     = 1'b1;
    bus.coin       = 2'b10;
    bus.coin_valid = 1'b1;
    step();
    bus.cancel     = 1'b0;
    bus.coin_valid = 1'b0;
    tests++;
    if (bus.coin_reject !== 1'b1 || bus.change_valid !== 1'b1 || bus.change !== 6'd5 ||
        bus.dispense !== 1'b0) begin
      fails++; $display("FAIL cancel: got rej %b cv %b change %0d disp %b expected 1/1/5/0",
                        bus.coin_reject, bus.change_valid, bus.change, bus.dispense);
    end
    step();
    tests++;
    if (bus.busy !== 1'b0 || bus.dispense !== 1'b0) begin
      fails++; $display("FAIL cancel_idle: got busy %b disp %b expected 0/0", bus.busy, bus.dispense);
    end
  endtask

  task automatic test_invalid_inputs;
    do_sel(3, cost_of(3));
    tests++;
    if (bus.sel_error !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL sel_error: got err %b busy %b expected 1/0", bus.sel_error, bus.busy);
    end
    step();
    tests++;
    if (bus.sel_error !== 1'b0) begin fails++; $display("FAIL sel_error_pulse: got %b expected 0", bus.sel_error); end
    do_sel(0, cost_of(0));
    do_coin(3);
    tests++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd0 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL bad_coin: got rej %b credit %0d busy %b expected 1/0/1",
                        bus.coin_reject, bus.credit, bus.busy);
    end
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    step();
  endtask

  task automatic test_timeout;
    int k;
    do_sel(1, cost_of(1));
    do_coin(0);
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      step();
      if (bus.change_valid === 1'b1) k = i;
    end
    tests++;
    if (k != TMO || bus.change !== 6'd5) begin
      fails++; $display("FAIL timeout: got cycles %0d change %0d expected %0d/5", k, bus.change, TMO);
    end
    step();
    // Coin in cycle 6 after the first coin restarts the count.
    do_sel(1, cost_of(1));
    do_coin(0);
    for (int i = 1; i <= 5; i++) step();
    do_coin(0);
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      step();
      if (bus.change_valid === 1'b1) k = i;
    end
    tests++;
    if (k != TMO || bus.change !== 6'd10) begin
      fails++; $display("FAIL timeout_restart: got cycles %0d change %0d expected %0d/10", k, bus.change, TMO);
    end
    step();
  endtask

  task automatic test_reset_mid;
    int seen;
    do_sel(2, cost_of(2));
    do_coin(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({bus.dispense, bus.dispensed_product, bus.change_valid, bus.change, bus.credit,
         bus.coin_reject, bus.sel_error, bus.busy} !== 20'd0) begin
      fails++;
      $display("FAIL reset_mid: got %h expected 0",
               {bus.dispense, bus.dispensed_product, bus.change_valid, bus.change, bus.credit,
                bus.coin_reject, bus.sel_error, bus.busy});
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.dispense === 1'b1 || bus.change_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL reset_mid_pulses: got %0d expected 0", seen); end
  endtask

  // Transaction-level model: credit is the sum of accepted coin values,
  // payment completes when the sum reaches the cost, refund on cancel or
  // after TMO edges without an accepted coin.
  task automatic test_random;
    int cost, code, acc, quiet, r, c;
    bit done, is_coin, is_cancel;
    for (int t = 0; t < 40; t++) begin
      cost  = $urandom_range(40, 1);
      code  = $urandom_range(2, 0);
      acc   = 0;
      quiet = 0;
      done  = 1'b0;
      do_sel(code, cost);
      tests++;
      if (bus.busy !== 1'b1) begin fails++; $display("FAIL rnd_busy t%0d: got %b expected 1", t, bus.busy); end
      while (!done) begin
        r = $urandom_range(9, 0);
        c = $urandom_range(3, 0);
        is_cancel = (r == 0);
        is_coin   = (r >= 1 && r <= 6);
        bus.cancel     = is_cancel;
        bus.coin       = c[1:0];
        bus.coin_valid = is_coin;
        step();
        bus.cancel     = 1'b0;
        bus.coin_valid = 1'b0;
        tests++;
        if (is_cancel) begin
          done = 1'b1;
          if (bus.change_valid !== 1'b1 || bus.change !== acc[5:0] || bus.dispense !== 1'b0) begin
            fails++; $display("FAIL rnd_cancel t%0d: got cv %b change %0d expected 1/%0d",
                              t, bus.change_valid, bus.change, acc);
          end
        end else if (is_coin && c != 3) begin
          acc += coin_val[c];
          quiet = 0;
          if (acc >= cost) begin
            done = 1'b1;
            if (bus.dispense !== 1'b1 || bus.dispensed_product !== code[1:0] || bus.credit !== acc[5:0]) begin
              fails++; $display("FAIL rnd_dispense t%0d: got disp %b prod %0d credit %0d expected 1/%0d/%0d",
                                t, bus.dispense, bus.dispensed_product, bus.credit, code, acc);
            end
            step();
            tests++;
            if (bus.change_valid !== 1'b1 || bus.change !== 6'(acc - cost)) begin
              fails++; $display("FAIL rnd_change t%0d: got cv %b change %0d expected 1/%0d",
                                t, bus.change_valid, bus.change, acc - cost);
            end
          end else if (bus.credit !== acc[5:0] || bus.dispense !== 1'b0) begin
            fails++; $display("FAIL rnd_credit t%0d: got %0d disp %b expected %0d/0", t, bus.credit, bus.dispense, acc);
          end
        end else begin
          quiet++;
          if (quiet == TMO) begin
            done = 1'b1;
            if (bus.change_valid !== 1'b1 || bus.change !== acc[5:0]) begin
              fails++; $display("FAIL rnd_timeout t%0d: got cv %b change %0d expected 1/%0d",
                                t, bus.change_valid, bus.change, acc);
            end
          end else if (bus.change_valid !== 1'b0 || bus.credit !== acc[5:0] ||
                       bus.coin_reject !== is_coin) begin
            fails++; $display("FAIL rnd_idle t%0d: got cv %b credit %0d rej %b expected 0/%0d/%b",
                              t, bus.change_valid, bus.credit, bus.coin_reject, acc, is_coin);
          end
        end
      end
      step();
      tests++;
      if (bus.busy !== 1'b0 || bus.credit !== 6'd0) begin
        fails++; $display("FAIL rnd_end t%0d: got busy %b credit %0d expected 0/0", t, bus.busy, bus.credit);
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.product_sel  = 2'd0;
    bus.product_cost = 6'd0;
    bus.sel_valid    = 1'b0;
    bus.coin         = 2'd0;
    bus.coin_valid   = 1'b0;
    bus.cancel       = 1'b0;
    test_reset();
    test_exact_payment();
    test_overpayment();
    test_cancel_with_coin();
    test_invalid_inputs();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction controller for the vending machine, sitting directly downstream of the product cost calculator. It latches a product selection together with its 6-bit cost and accumulates inserted coins into a credit register. It then issues a one-cycle dispense pulse and a one-cycle change/refund pulse. Cancel and an inactivity timeout both refund the full credit.

## Interface
- TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before automatic refund; must be ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- product_sel  input  2  product code, also routed to the cost calculator.
- product_cost  input  6  cost from the cost calculator for the current product_sel (0 = invalid code).
- sel_valid  input  1  one-cycle strobe: product_sel/product_cost are valid.
- coin  input  2  denomination code: 00 = 5, 01 = 10, 10 = 20, 11 = invalid.
- coin_valid  input  1  one-cycle strobe: a coin is present on `coin`.
- cancel  input  1  user cancel request.
- dispense  output  1  one-cycle pulse: release the product.
- dispensed_product  output  2  latched product code; valid while dispense = 1.
- change_valid  output  1  one-cycle pulse: `change` is valid.
- change  output  6  amount to return; refund or overpayment.
- credit  output  6  current accumulated credit.
- coin_reject  output  1  one-cycle pulse: coin returned unaccepted.
- sel_error  output  1  one-cycle pulse: selection rejected because cost = 0.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- Reset values: state IDLE; all outputs 0; latched sel/cost 0; timeout counter 0.
- IDLE:
  - On sel_valid with product_cost ≠ 0: latch product_sel and product_cost, then go to COLLECT.
  - On sel_valid with product_cost = 0: pulse sel_error and stay in IDLE.
  - A coin_valid in IDLE pulses coin_reject.
- COLLECT, in priority order:
  - cancel: go to CHANGE with refund = credit. A coin arriving in the same cycle is rejected (coin_reject).
  - Valid coin: new credit = credit + value. Clear the timeout counter. If new credit ≥ latched cost, go to DISPENSE; otherwise stay in COLLECT.
  - Coin code 11: pulse coin_reject. Credit is unchanged and the timeout counter is not cleared.
  - Timeout counter reaches TIMEOUT_CYCLES−1 with no coin: go to CHANGE with refund = credit.
  - sel_valid is ignored. The product is locked once selected.
- DISPENSE:
  - Assert dispense for exactly one cycle, with dispensed_product = latched sel.
  - Register change = credit − cost. The result is never negative.
  - Go to CHANGE.
- CHANGE:
  - Assert change_valid for one cycle. The amount may be 0.
  - Clear credit, then go to IDLE.
- Coins arriving in DISPENSE or CHANGE are rejected. cancel is ignored outside COLLECT.
- Arithmetic:
  - Credit never exceeds 35 + 20 = 55, because COLLECT exits as soon as credit ≥ cost (max cost 40). No overflow is possible in 6 bits.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates at terminal count.
- Reset mid-operation: immediate return to IDLE with credit lost. No dispense or change pulse is emitted.

## Timing
- All outputs are registered, and all inputs are sampled on the rising edge.
- Selection latency: sel_valid sampled at edge N means busy = 1 and state = COLLECT after edge N.
- Coin latency: coin sampled at edge N means credit is updated after edge N. If paid, dispense is high during cycle N+1 (after edge N).
- change_valid is high in the cycle immediately following the dispense cycle.
- Cancel sampled at edge N: change_valid = 1 with change = credit during the cycle after edge N. No dispense is issued.
- Timeout: TIMEOUT_CYCLES consecutive coin-free cycles in COLLECT trigger a refund on the next cycle.
- sel_error and coin_reject are high for the cycle after the offending strobe.
- busy deasserts the cycle after change_valid.

## Test plan
- Exact payment: sel 01 (cost 20), coins 10 then 10 → credit 10 then 20; dispense = 1 with dispensed_product = 01; then change_valid with change = 0; busy drops.
- Overpayment: sel 10 (cost 40), coins 20, 5, 20 → credit 20, 25, 45; dispense with dispensed_product = 10; change = 5.
- Cancel with a simultaneous coin: sel 00 (cost 10), coin 5, then cancel together with coin 20 → coin_reject = 1; change_valid with change = 5; no dispense.
- Invalid inputs: sel 11 (cost 0) → sel_error, busy stays 0. Then sel 00 followed by coin code 11 → coin_reject, credit stays 0.
- Timeout (TIMEOUT_CYCLES = 8): sel 01, coin 5, then no activity → change_valid with change = 5 exactly 8 cycles after the coin. A coin arriving in cycle 6 restarts the count.
- Reset mid-transaction: sel 10, coin 20, then rst → the cycle after rst, all outputs are 0 and state is IDLE; no dispense or change ever appears.
